// File: rtl/addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int num_slices(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple-carry slice; also exposes the carry into its MSB
// so the top level can form the signed-overflow flag on the final slice.
module addsub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             c_in,
  output logic [DIGIT-1:0] s_d,
  output logic             c_out,
  output logic             c_msb_in
);

  logic c;

  always_comb begin
    c        = c_in;
    c_msb_in = c_in;
    s_d      = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb_in = c;
      s_d[i] = a_d[i] ^ b_d[i] ^ c;
      c      = (a_d[i] & b_d[i]) | (c & (a_d[i] ^ b_d[i]));
    end
    c_out = c;
  end

endmodule

// File: rtl/serial_addsub_unit.sv
// Digit-serial add/subtract unit: DIGIT bits per clock, LSB first, start/done handshake.
// Optional signed saturation of the result is enabled by SERIAL_ADDSUB_SATURATE_EN.
module serial_addsub_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSL = num_slices(WIDTH, DIGIT);
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

  if (WIDTH < 2) begin : g_bad_width
    $error("serial_addsub_unit: WIDTH must be at least 2");
  end
  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_addsub_unit: WIDTH must be a positive multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, s_q, s_d;
  logic             sub_q, sub_d, c_q, c_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [DIGIT-1:0] sl_a, sl_b, sl_s;
  logic             sl_c, sl_cmsb;
  logic             last;
  logic [WIDTH-1:0] res_fin, s_fin;
  logic             ovf_fin, cout_fin;

  // b is stored pre-inverted for subtract, so the slice is always a plain adder
  assign sl_a = a_q[DIGIT*int'(cnt_q) +: DIGIT];
  assign sl_b = b_q[DIGIT*int'(cnt_q) +: DIGIT];
  assign last = (int'(cnt_q) == NSL - 1);

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a_d      (sl_a),
    .b_d      (sl_b),
    .c_in     (c_q),
    .s_d      (sl_s),
    .c_out    (sl_c),
    .c_msb_in (sl_cmsb)
  );

  assign res_fin  = (res_q >> DIGIT) | (WIDTH'(sl_s) << (WIDTH - DIGIT));
  assign ovf_fin  = sl_cmsb ^ sl_c;
  assign cout_fin = (sub_q == MODE_ADD) ? sl_c : ~sl_c;

`ifdef SERIAL_ADDSUB_SATURATE_EN
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] val,
                                                input logic ov, input logic sign);
    if (!ov) return val;
    return sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  // On overflow the true result has the sign of operand A
  assign s_fin = saturate(res_fin, ovf_fin, a_q[WIDTH-1]);
`else
  assign s_fin = res_fin;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    c_d     = c_q;
    res_d   = res_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      RUN: begin
        c_d   = sl_c;
        res_d = res_fin;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          s_d     = s_fin;
          cout_d  = cout_fin;
          ovf_d   = ovf_fin;
          zero_d  = (s_fin == '0);
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          a_d     = a;
          b_d     = (sub == MODE_SUB) ? ~b : b;
          sub_d   = sub;
          c_d     = (sub == MODE_SUB) ? ~cin : cin;
          res_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      c_q     <= 1'b0;
      res_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      c_q     <= c_d;
      res_q   <= res_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule
